// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: access width codes, FSM state
// encoding and the byte-enable size mask.
package mem_lsu_pkg;

   localparam logic [1:0] WIDTH_BYTE  = 2'b00;
   localparam logic [1:0] WIDTH_HALF  = 2'b01;
   localparam logic [1:0] WIDTH_WORD  = 2'b10;
   localparam logic [1:0] WIDTH_DWORD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_REQ    = 2'b01,
      ST_WAIT_R = 2'b10,
      ST_HOLD   = 2'b11
   } lsu_state_t;

   // Unshifted byte-enable mask for an access width, sized for the widest bus.
   function automatic logic [7:0] be_mask(input logic [1:0] width);
      case (width)
         WIDTH_BYTE: be_mask = 8'h01;
         WIDTH_HALF: be_mask = 8'h03;
         WIDTH_WORD: be_mask = 8'h0F;
         default:    be_mask = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store replication and byte enables, load lane
// extraction with sign/zero extension, and misalignment detection.
module mem_lane_align
   import mem_lsu_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic [1:0]                       width,
   input  logic                             sign_flag,
   input  logic [$clog2(NB_DATA/8)-1:0]     offset,
   input  logic [NB_DATA-1:0]               store_data,
   input  logic [NB_DATA-1:0]               load_raw,
   output logic [NB_DATA/8-1:0]             be,
   output logic [NB_DATA-1:0]               store_lanes,
   output logic [NB_DATA-1:0]               load_fmt,
   output logic                             misaligned
);

   localparam int NB_BE = NB_DATA / 8;

   logic [NB_BE-1:0]   size_mask;
   logic [NB_DATA-1:0] shifted;
   logic               top_bit;
   int                 nbits;

   assign size_mask = NB_BE'(be_mask(width));
   assign be        = size_mask << offset;

   genvar gi;
   generate
      for (gi = 0; gi < NB_BE; gi++) begin : g_lane
         assign store_lanes[8*gi +: 8] =
            (width == WIDTH_BYTE) ? store_data[7:0] :
            (width == WIDTH_HALF) ? store_data[8*(gi%2) +: 8] :
            (width == WIDTH_WORD) ? store_data[8*(gi%4) +: 8] :
                                    store_data[8*gi +: 8];
      end
   endgenerate

   // Bring the addressed lane down to bit 0, then extend above its size.
   always_comb begin
      shifted = load_raw >> {offset, 3'b000};
      nbits   = NB_DATA;
      top_bit = shifted[NB_DATA-1];
      case (width)
         WIDTH_BYTE: begin nbits = 8;  top_bit = shifted[7];  end
         WIDTH_HALF: begin nbits = 16; top_bit = shifted[15]; end
         WIDTH_WORD: begin nbits = 32; top_bit = shifted[31]; end
         default:    ;
      endcase
      for (int i = 0; i < NB_DATA; i++) begin
         load_fmt[i] = (i < nbits) ? shifted[i] : (sign_flag & top_bit);
      end
   end

   always_comb begin
      case (width)
         WIDTH_BYTE: misaligned = 1'b0;
         WIDTH_HALF: misaligned = offset[0];
         WIDTH_WORD: misaligned = (offset[1:0] != 2'b00);
         default:    misaligned = (NB_DATA == 32) || (offset != '0);
      endcase
   end

endmodule

// File: rtl/mem_access_lsu.sv
// MEM stage: drives a req/gnt/rvalid data memory, stalls while a transaction
// is outstanding and registers the MEM/WB outputs.
module mem_access_lsu
   import mem_lsu_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 10
) (
   input  logic                 clk,
   input  logic                 i_rst_n,
   input  logic                 i_halt,
   input  logic [4:0]           i_reg2write,
   input  logic [NB_DATA-1:0]   i_result,
   input  logic [NB_DATA-1:0]   i_data4Mem,
   input  logic [1:0]           i_width,
   input  logic                 i_sign_flag,
   input  logic                 i_mem2reg,
   input  logic                 i_memRead,
   input  logic                 i_memWrite,
   input  logic                 i_regWrite,
   output logic                 o_mem_req,
   output logic                 o_mem_we,
   output logic [NB_ADDR-1:0]   o_mem_addr,
   output logic [NB_DATA/8-1:0] o_mem_be,
   output logic [NB_DATA-1:0]   o_mem_wdata,
   input  logic                 i_mem_gnt,
   input  logic                 i_mem_rvalid,
   input  logic [NB_DATA-1:0]   i_mem_rdata,
   output logic                 o_stall,
   output logic [NB_DATA-1:0]   o_reg_read,
   output logic [NB_DATA-1:0]   o_ALUresult,
   output logic [4:0]           o_reg2write,
   output logic                 o_mem2reg,
   output logic                 o_regWrite,
   output logic                 o_misaligned
);

   localparam int OFF_W = $clog2(NB_DATA/8);

   lsu_state_t         state_reg;
   logic [NB_DATA-1:0] capture_reg;
   logic [NB_DATA-1:0] load_fmt;
   logic               misaligned;
   logic               access, go, is_store, store_done, load_done;
   logic               stall, load_en, bubble;
   logic [NB_DATA-1:0] read_sel;

   mem_lane_align #(.NB_DATA(NB_DATA)) u_align (
      .width       (i_width),
      .sign_flag   (i_sign_flag),
      .offset      (i_result[OFF_W-1:0]),
      .store_data  (i_data4Mem),
      .load_raw    (i_mem_rdata),
      .be          (o_mem_be),
      .store_lanes (o_mem_wdata),
      .load_fmt    (load_fmt),
      .misaligned  (misaligned)
   );

   assign access     = i_memRead | i_memWrite;
   assign go         = access & ~misaligned;
   assign is_store   = i_memWrite;
   assign o_mem_req  = (state_reg == ST_REQ) | ((state_reg == ST_IDLE) & go & ~i_halt);
   assign o_mem_we   = o_mem_req & is_store;
   assign o_mem_addr = i_result[NB_ADDR-1:0];
   assign store_done = o_mem_req & i_mem_gnt & is_store;
   assign load_done  = (state_reg == ST_WAIT_R) & i_mem_rvalid;

   // HOLD already has its data; it only waits for the halt to drop.
   assign stall    = (state_reg == ST_HOLD) ? i_halt : (go & ~(store_done | load_done));
   assign o_stall  = stall;
   assign load_en  = ~i_halt & ~stall;
   assign bubble   = ~i_halt & stall;
   assign read_sel = (state_reg == ST_HOLD) ? capture_reg : load_fmt;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg    <= ST_IDLE;
         capture_reg  <= '0;
         o_reg_read   <= '0;
         o_ALUresult  <= '0;
         o_reg2write  <= '0;
         o_mem2reg    <= 1'b0;
         o_regWrite   <= 1'b0;
         o_misaligned <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (go && !i_halt) begin
                  if (i_mem_gnt) state_reg <= is_store ? ST_IDLE : ST_WAIT_R;
                  else           state_reg <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (i_mem_gnt) state_reg <= is_store ? ST_IDLE : ST_WAIT_R;
            end
            ST_WAIT_R: begin
               if (i_mem_rvalid) begin
                  capture_reg <= load_fmt;
                  state_reg   <= i_halt ? ST_HOLD : ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (!i_halt) state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase

         if (load_en) begin
            o_reg_read   <= (go & ~is_store) ? read_sel : '0;
            o_ALUresult  <= i_result;
            o_reg2write  <= i_reg2write;
            o_mem2reg    <= i_mem2reg;
            o_regWrite   <= i_regWrite & ~(access & misaligned);
            o_misaligned <= access & misaligned;
         end else if (bubble) begin
            // Bubble keeps the stalled instruction from writing back twice.
            o_regWrite   <= 1'b0;
            o_mem2reg    <= 1'b0;
            o_misaligned <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_lsu.sv
// Directed bench for mem_access_lsu: a vector table of single transactions
// plus hand-written latency, reset and halt sequences.
module tb_mem_access_lsu;

   logic        clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_halt = 1'b0;
   logic [4:0]  i_reg2write = '0;
   logic [31:0] i_result = '0, i_data4Mem = '0, i_mem_rdata = '0;
   logic [1:0]  i_width = '0;
   logic        i_sign_flag = 1'b0, i_mem2reg = 1'b0, i_memRead = 1'b0;
   logic        i_memWrite = 1'b0, i_regWrite = 1'b0;
   logic        i_mem_gnt = 1'b0, i_mem_rvalid = 1'b0;
   logic        o_mem_req, o_mem_we, o_stall, o_mem2reg, o_regWrite, o_misaligned;
   logic [9:0]  o_mem_addr;
   logic [3:0]  o_mem_be;
   logic [31:0] o_mem_wdata, o_reg_read, o_ALUresult;
   logic [4:0]  o_reg2write;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_access_lsu #(.NB_DATA(32), .NB_ADDR(10)) dut (
      .clk(clk), .i_rst_n(i_rst_n), .i_halt(i_halt), .i_reg2write(i_reg2write),
      .i_result(i_result), .i_data4Mem(i_data4Mem), .i_width(i_width),
      .i_sign_flag(i_sign_flag), .i_mem2reg(i_mem2reg), .i_memRead(i_memRead),
      .i_memWrite(i_memWrite), .i_regWrite(i_regWrite), .o_mem_req(o_mem_req),
      .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be),
      .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid),
      .i_mem_rdata(i_mem_rdata), .o_stall(o_stall), .o_reg_read(o_reg_read),
      .o_ALUresult(o_ALUresult), .o_reg2write(o_reg2write), .o_mem2reg(o_mem2reg),
      .o_regWrite(o_regWrite), .o_misaligned(o_misaligned)
   );

   typedef struct {
      string       name;
      logic [1:0]  width;
      logic        sgn, rd, wr, rw, m2r;
      logic [4:0]  dst;
      logic [31:0] addr, data, rdata;
      logic        exp_req;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic        exp_mis, exp_regw;
      logic [31:0] exp_rread;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] w, input logic s, input logic rd, input logic wr,
                        input logic rw, input logic m2r, input logic [4:0] dst,
                        input logic [31:0] addr, input logic [31:0] data);
      i_width = w; i_sign_flag = s; i_memRead = rd; i_memWrite = wr;
      i_regWrite = rw; i_mem2reg = m2r; i_reg2write = dst;
      i_result = addr; i_data4Mem = data;
   endtask

   task automatic nop();
      drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
   endtask

   task automatic run_vec(input vec_t v);
      logic is_load;
      is_load = v.exp_req & v.rd & ~v.wr;
      @(negedge clk);
      drive(v.width, v.sgn, v.rd, v.wr, v.rw, v.m2r, v.dst, v.addr, v.data);
      i_mem_gnt = 1'b1; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
      #1;
      chk({v.name, ".req"}, 32'(o_mem_req), 32'(v.exp_req));
      chk({v.name, ".stall"}, 32'(o_stall), 32'(is_load));
      if (v.exp_req) chk({v.name, ".be"}, 32'(o_mem_be), 32'(v.exp_be));
      if (v.exp_req && v.wr) begin
         chk({v.name, ".wdata"}, o_mem_wdata, v.exp_wdata);
         chk({v.name, ".we"}, 32'(o_mem_we), 32'd1);
      end
      @(posedge clk); #1;
      if (is_load) begin
         chk({v.name, ".bubble_regw"}, 32'(o_regWrite), 32'd0);
         @(negedge clk);
         i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = v.rdata;
         #1 chk({v.name, ".stall_done"}, 32'(o_stall), 32'd0);
         @(posedge clk); #1;
         chk({v.name, ".rread"}, o_reg_read, v.exp_rread);
      end
      chk({v.name, ".regw"}, 32'(o_regWrite), 32'(v.exp_regw));
      chk({v.name, ".mis"}, 32'(o_misaligned), 32'(v.exp_mis));
      chk({v.name, ".alu"}, o_ALUresult, v.addr);
      chk({v.name, ".dst"}, 32'(o_reg2write), 32'(v.dst));
      chk({v.name, ".m2r"}, 32'(o_mem2reg), 32'(v.m2r));
      @(negedge clk); nop();
      @(posedge clk); #1;
      chk({v.name, ".after_mis"}, 32'(o_misaligned), 32'd0);
      chk({v.name, ".after_regw"}, 32'(o_regWrite), 32'd0);
      $display("[TB] vector %s addr=0x%02h done", v.name, v.addr[7:0]);
   endtask

   initial begin
      int stall_cnt, pulses;
      //            name      w  s  rd wr rw m2r dst  addr          data          rdata         req be     wdata        mis regw rread
      vecs[0]  = '{"st_b",   0, 0, 0, 1, 0, 0, 5'd1, 32'h13,       32'hAABBCCDD, 32'h0,        1, 4'h8, 32'hDDDDDDDD, 0, 0, 32'h0};
      vecs[1]  = '{"st_h",   1, 0, 0, 1, 0, 0, 5'd2, 32'h12,       32'h11223344, 32'h0,        1, 4'hC, 32'h33443344, 0, 0, 32'h0};
      vecs[2]  = '{"st_w",   2, 0, 0, 1, 0, 0, 5'd3, 32'h10,       32'hCAFEBABE, 32'h0,        1, 4'hF, 32'hCAFEBABE, 0, 0, 32'h0};
      vecs[3]  = '{"ld_bs",  0, 1, 1, 0, 1, 1, 5'd4, 32'h13,       32'h0,        32'h80112233, 1, 4'h8, 32'h0,        0, 1, 32'hFFFFFF80};
      vecs[4]  = '{"ld_hu",  1, 0, 1, 0, 1, 1, 5'd5, 32'h02,       32'h0,        32'h80011234, 1, 4'hC, 32'h0,        0, 1, 32'h00008001};
      vecs[5]  = '{"ld_hs",  1, 1, 1, 0, 1, 1, 5'd6, 32'h00,       32'h0,        32'h0000F00D, 1, 4'h3, 32'h0,        0, 1, 32'hFFFFF00D};
      vecs[6]  = '{"ld_bu",  0, 0, 1, 0, 1, 1, 5'd7, 32'h11,       32'h0,        32'h0000AB00, 1, 4'h2, 32'h0,        0, 1, 32'h000000AB};
      vecs[7]  = '{"ld_w",   2, 0, 1, 0, 1, 1, 5'd8, 32'h04,       32'h0,        32'h89ABCDEF, 1, 4'hF, 32'h0,        0, 1, 32'h89ABCDEF};
      vecs[8]  = '{"mis_lw", 2, 0, 1, 0, 1, 1, 5'd9, 32'h06,       32'h0,        32'h0,        0, 4'h0, 32'h0,        1, 0, 32'h0};
      vecs[9]  = '{"mis_sh", 1, 0, 0, 1, 0, 0, 5'd10, 32'h01,      32'h1234,     32'h0,        0, 4'h0, 32'h0,        1, 0, 32'h0};
      vecs[10] = '{"mis_ld", 3, 0, 1, 0, 1, 1, 5'd11, 32'h08,      32'h0,        32'h0,        0, 4'h0, 32'h0,        1, 0, 32'h0};
      vecs[11] = '{"alu",    0, 0, 0, 0, 1, 0, 5'd12, 32'h12345678, 32'h0,       32'h0,        0, 4'h0, 32'h0,        0, 1, 32'h0};

      // Reset state
      nop();
      #12;
      chk("rst.req", 32'(o_mem_req), 32'd0);
      chk("rst.stall", 32'(o_stall), 32'd0);
      chk("rst.alu", o_ALUresult, 32'd0);
      chk("rst.rread", o_reg_read, 32'd0);
      chk("rst.flags", {27'd0, o_reg2write} | 32'({o_mem2reg, o_regWrite, o_misaligned}), 32'd0);
      @(negedge clk); i_rst_n = 1'b1;

      foreach (vecs[k]) run_vec(vecs[k]);

      // Word load: grant after 3 cycles, rvalid 2 cycles after grant
      stall_cnt = 0; pulses = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         drive(2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 32'h08, 32'h0);
         i_mem_gnt = (cyc == 3); i_mem_rvalid = (cyc == 5); i_mem_rdata = 32'h0BADF00D;
         #1;
         chk($sformatf("lat.req%0d", cyc), 32'(o_mem_req), 32'(cyc <= 3));
         if (o_stall) stall_cnt++;
         @(posedge clk); #1;
         if (o_regWrite) pulses++;
         $display("[TB] latency cycle %0d stall=%0b regWrite=%0b", cyc, o_stall, o_regWrite);
      end
      chk("lat.regw_at_done", 32'(o_regWrite), 32'd1);
      chk("lat.rread", o_reg_read, 32'h0BADF00D);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); nop();
         @(posedge clk); #1;
         if (o_regWrite) pulses++;
      end
      chk("lat.stall_cycles", 32'(stall_cnt), 32'd5);
      chk("lat.regw_pulses", 32'(pulses), 32'd1);

      // Reset while waiting for rvalid; the late rvalid must be ignored
      @(negedge clk);
      drive(2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd14, 32'h00, 32'h0);
      i_mem_gnt = 1'b1;
      @(posedge clk);
      @(negedge clk);
      nop(); i_rst_n = 1'b0;
      #1;
      chk("rstw.alu", o_ALUresult, 32'd0);
      chk("rstw.stall", 32'(o_stall), 32'd0);
      @(posedge clk);
      @(negedge clk);
      i_rst_n = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      chk("rstw.regw", 32'(o_regWrite), 32'd0);
      chk("rstw.rread", o_reg_read, 32'd0);
      @(negedge clk);
      i_mem_rvalid = 1'b0;
      drive(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h20, 32'h55AA55AA);
      i_mem_gnt = 1'b1;
      #1;
      chk("rstw.idle_req", 32'(o_mem_req), 32'd1);
      chk("rstw.idle_stall", 32'(o_stall), 32'd0);
      @(posedge clk); #1;
      $display("[TB] reset-in-WAIT_R sequence done");

      // Halt during WAIT_R: data is held and presented after release
      @(negedge clk);
      drive(2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd15, 32'h13, 32'h0);
      i_mem_gnt = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_mem_gnt = 1'b0; i_halt = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h80112233;
      @(posedge clk);
      @(negedge clk);
      i_mem_rvalid = 1'b0; i_mem_rdata = '0;
      #1 chk("halt.stall_hold", 32'(o_stall), 32'd1);
      @(posedge clk); #1;
      chk("halt.regw_frozen", 32'(o_regWrite), 32'd0);
      chk("halt.alu_frozen", o_ALUresult, 32'h20);
      @(negedge clk);
      i_halt = 1'b0;
      #1 chk("halt.stall_release", 32'(o_stall), 32'd0);
      @(posedge clk); #1;
      chk("halt.rread", o_reg_read, 32'hFFFFFF80);
      chk("halt.regw", 32'(o_regWrite), 32'd1);
      chk("halt.alu", o_ALUresult, 32'h13);
      @(negedge clk); nop();
      @(posedge clk); #1;
      chk("halt.single_pulse", 32'(o_regWrite), 32'd0);
      $display("[TB] halt-in-WAIT_R sequence done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_access_lsu.md
# mem_access_lsu

Parametrised successor to the MIPS memory-access pipeline stage. Sits between the execute stage and write-back. It drives an external data memory through a request/grant/response handshake with byte enables, and formats load data (byte, half, word, and dword when NB_DATA=64) with sign or zero extension. It detects misaligned accesses, stalls the pipeline while a transaction is outstanding, and registers the MEM/WB outputs.

## Interface
- NB_DATA, 32, datapath width; legal values 32 or 64.
- NB_ADDR, 10, byte-address width presented to memory.
- clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_halt  in  1  freezes output register and blocks new requests.
- i_reg2write  in  5  destination register.
- i_result  in  NB_DATA  ALU result / byte address.
- i_data4Mem  in  NB_DATA  store source data.
- i_width  in  2  00 byte, 01 half, 10 word, 11 dword.
- i_sign_flag  in  1  1 = sign-extend load, 0 = zero-extend.
- i_mem2reg, i_memRead, i_memWrite, i_regWrite  in  1 each  control.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  1 = store.
- o_mem_addr  out  NB_ADDR  byte address, i_result[NB_ADDR-1:0].
- o_mem_be  out  NB_DATA/8  byte enables.
- o_mem_wdata  out  NB_DATA  lane-replicated store data.
- i_mem_gnt  in  1  request accepted.
- i_mem_rvalid  in  1  load data valid.
- i_mem_rdata  in  NB_DATA  load data, full bus.
- o_stall  out  1  upstream must hold all inputs stable.
- o_reg_read  out  NB_DATA  formatted load data.
- o_ALUresult  out  NB_DATA  registered i_result.
- o_reg2write  out  5  registered destination.
- o_mem2reg, o_regWrite  out  1  registered control.
- o_misaligned  out  1  registered one-cycle exception flag.

## Operation
- access = i_memRead | i_memWrite.
- misaligned = any of:
  - half with addr[0] set;
  - word with addr[1:0] nonzero;
  - dword with addr[2:0] nonzero;
  - dword when NB_DATA=32.
- Misaligned access:
  - no request, no stall;
  - registered o_misaligned=1 for one cycle;
  - o_regWrite=0 for that instruction.
- Store formatting:
  - o_mem_wdata replicates the low byte, half or word of i_data4Mem across the bus;
  - o_mem_be = size mask shifted by the address offset.
- Load formatting:
  - extract the lane at the address offset from i_mem_rdata;
  - extend to NB_DATA per i_sign_flag.
- FSM states: IDLE, REQ, WAIT_R, HOLD.
  - IDLE: on an aligned access with !i_halt, o_mem_req=1 combinationally.
    - gnt + store → stay IDLE.
    - gnt + load → WAIT_R.
    - no gnt → REQ.
  - REQ: o_mem_req=1, address/be/wdata held stable.
    - gnt + store → IDLE.
    - gnt + load → WAIT_R.
  - WAIT_R: on rvalid, capture formatted data.
    - !i_halt → IDLE.
    - i_halt → HOLD.
  - HOLD: keep captured data; go to IDLE when i_halt falls.
- o_stall = access & !misaligned & !(transaction completes this cycle). Completion means a store granted or a load rvalid.
- Also stalled: IDLE with i_halt while an access waits.
- HOLD stalls until release.
- Output register loads when !i_halt & !o_stall.
- When o_stall & !i_halt, a bubble is loaded: o_regWrite=0, o_mem2reg=0, other outputs hold. This prevents double write-back.
- When i_halt, everything holds.
- i_mem_rvalid outside WAIT_R is ignored.

## Timing
- Reset: all outputs 0, state IDLE, o_mem_req 0, capture buffer 0.
- Reset mid-transaction returns to IDLE immediately; a later rvalid is ignored.
- Zero-wait store: 1 cycle, no stall.
- Load latency: 1 + gnt wait + rvalid wait cycles. o_stall is high on every cycle except the completing one.
- o_reg_read is valid the cycle after rvalid (HOLD: after halt release).
- Non-memory instructions pass through with 1-cycle latency.

## Structure
- Package mem_lsu_pkg:
  - width codes WIDTH_BYTE/HALF/WORD/DWORD;
  - FSM state encoding;
  - function for the byte-enable mask.
- Combinational sub-module mem_lane_align: store replication/byte enables, load extraction/extension, misaligned detect.
- FSM and MEM/WB registers live in the top module.

## Test plan
- Store byte, addr 0x13, data 0xAABBCCDD, gnt same cycle → be=4'b1000, wdata=0xDDDDDDDD, we=1, no stall.
- Load byte signed, addr 0x13, rdata 0x80112233 → o_reg_read=0xFFFFFF80.
- Load half unsigned, addr 0x02, rdata 0x80011234 → o_reg_read=0x00008001.
- Load word, gnt after 3 cycles, rvalid 2 cycles after gnt:
  - o_stall high 5 cycles;
  - exactly one o_regWrite=1 pulse;
  - bubbles carry regWrite=0.
- Word load at 0x06 → no o_mem_req, o_misaligned=1 one cycle, o_regWrite=0.
- Mixed reset and halt cases:
  - i_rst_n low in WAIT_R, then rvalid → outputs stay 0, state IDLE;
  - i_halt during WAIT_R → HOLD, data presented after release.
